// File: rtl/frame_pkg.sv
// Shared screen geometry, pixel type and blitter state encoding.
package frame_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef logic [15:0] rgb565_t;
  localparam rgb565_t KEY_COLOR_DEF = 16'hF81F;

  typedef enum logic [1:0] {IDLE, FETCH, EMIT} blit_state_e;
endpackage

// File: rtl/sprite_blitter_if.sv
// Draw-command handshake into the sprite blitter.
interface sprite_blitter_if #(parameter int ID_W = 5);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [9:0]      cmd_x;
  logic [9:0]      cmd_y;
  logic [ID_W-1:0] cmd_id;
  logic            cmd_flip;

  modport master (output cmd_valid, cmd_x, cmd_y, cmd_id, cmd_flip, input cmd_ready);
  modport slave  (input cmd_valid, cmd_x, cmd_y, cmd_id, cmd_flip, output cmd_ready);
endinterface

// File: rtl/sprite_blit_walker.sv
// Row/col walk over one sprite, per-pixel hold counter and registered ROM address.
module sprite_blit_walker #(
  parameter int SPRITE_W   = 32,
  parameter int SPRITE_H   = 32,
  parameter int ID_W       = 5,
  parameter int PIXEL_HOLD = 4,
  localparam int CW = $clog2(SPRITE_W),
  localparam int RW = $clog2(SPRITE_H),
  localparam int HW = $clog2(PIXEL_HOLD)
) (
  input  logic               sram_clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [ID_W-1:0]    id,
  input  logic               flip,
  input  logic               emit,
  output logic [RW-1:0]      row,
  output logic [CW-1:0]      col,
  output logic [ID_W+RW+CW-1:0] rom_addr,
  output logic               hold_done,
  output logic               last
);
  logic [RW+CW-1:0] pix, pix_nx;
  logic [HW-1:0]    hold_cnt;
  logic [ID_W-1:0]  id_q, id_nx;
  logic             flip_q, flip_nx;
  logic [CW-1:0]    col_nx;

  assign {row, col} = pix;
  assign hold_done  = emit && (hold_cnt == HW'(PIXEL_HOLD - 1));
  assign last       = (pix == '1);

  // {row,col} is one counter: col wrap carries into row for free.
  always_comb begin
    pix_nx = pix;
    if (start)          pix_nx = '0;
    else if (hold_done) pix_nx = pix + 1'b1;
  end

  assign id_nx   = start ? id : id_q;
  assign flip_nx = start ? flip : flip_q;
  assign col_nx  = pix_nx[CW-1:0];

  // Address tracks the next pixel so the ROM word is ready when EMIT starts.
  always_ff @(posedge sram_clk) begin
    if (!reset_n) begin
      pix      <= '0;
      hold_cnt <= '0;
      id_q     <= '0;
      flip_q   <= 1'b0;
      rom_addr <= '0;
    end else begin
      pix      <= pix_nx;
      id_q     <= id_nx;
      flip_q   <= flip_nx;
      hold_cnt <= (!emit || hold_done) ? '0 : hold_cnt + 1'b1;
      rom_addr <= {id_nx, pix_nx[RW+CW-1:CW], flip_nx ? ~col_nx : col_nx};
    end
  end
endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: command handshake, frame-switch abort and program-write port drive.
module sprite_blitter
  import frame_pkg::*;
#(
  parameter int      SPRITE_W   = 32,
  parameter int      SPRITE_H   = 32,
  parameter int      ID_W       = 5,
  parameter int      PIXEL_HOLD = 4,
  parameter rgb565_t KEY_COLOR  = KEY_COLOR_DEF
) (
  input  logic        sram_clk,
  input  logic        reset_n,
  sprite_blitter_if.slave cmd,
  output logic [ID_W+$clog2(SPRITE_W)+$clog2(SPRITE_H)-1:0] rom_addr,
  input  rgb565_t     rom_data,
  input  logic        current_frame,
  output logic [9:0]  program_x,
  output logic [9:0]  program_y,
  output rgb565_t     program_data,
  output logic        program_write,
  output logic        busy,
  output logic        overrun
);
  localparam int CW = $clog2(SPRITE_W);
  localparam int RW = $clog2(SPRITE_H);

  blit_state_e   state, state_nx;
  logic [9:0]    x_q, y_q;
  logic          frame_d, abort_pend, on_q;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          hold_done, last;
  logic          accept, frame_edge, abort, emit;
  logic [10:0]   x_sum, y_sum;

  assign accept     = cmd.cmd_valid & cmd.cmd_ready;
  assign frame_edge = current_frame ^ frame_d;
  // An edge landing on the accept cycle is remembered and kills the command in FETCH.
  assign abort      = (state != IDLE) & (frame_edge | abort_pend);
  assign emit       = (state == EMIT);
  assign x_sum      = {1'b0, x_q} + 11'(col);
  assign y_sum      = {1'b0, y_q} + 11'(row);

  sprite_blit_walker #(
    .SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H), .ID_W(ID_W), .PIXEL_HOLD(PIXEL_HOLD)
  ) u_walker (
    .sram_clk  (sram_clk),
    .reset_n   (reset_n),
    .start     (accept),
    .id        (cmd.cmd_id),
    .flip      (cmd.cmd_flip),
    .emit      (emit),
    .row       (row),
    .col       (col),
    .rom_addr  (rom_addr),
    .hold_done (hold_done),
    .last      (last)
  );

  always_comb begin
    state_nx      = state;
    program_write = 1'b0;
    program_data  = '0;
    busy          = (state != IDLE);
    case (state)
      IDLE:  if (accept) state_nx = FETCH;
      FETCH: state_nx = abort ? IDLE : EMIT;
      EMIT: begin
        program_data  = rom_data;
        program_write = on_q & (rom_data != KEY_COLOR) & ~abort;
        if (abort)          state_nx = IDLE;
        else if (hold_done) state_nx = last ? IDLE : FETCH;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sram_clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      cmd.cmd_ready <= 1'b1;
      x_q           <= '0;
      y_q           <= '0;
      program_x     <= '0;
      program_y     <= '0;
      on_q          <= 1'b0;
      frame_d       <= current_frame;
      abort_pend    <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      state         <= state_nx;
      cmd.cmd_ready <= (state_nx == IDLE);
      frame_d       <= current_frame;
      abort_pend    <= accept & frame_edge;
      overrun       <= abort;
      if (accept) begin
        x_q <= cmd.cmd_x;
        y_q <= cmd.cmd_y;
      end
      // Coordinates and the clip decision are frozen for the coming EMIT window.
      if (state == FETCH) begin
        program_x <= x_sum[9:0];
        program_y <= y_sum[9:0];
        on_q      <= (x_sum < 11'(SCREEN_W)) && (y_sum < 11'(SCREEN_H));
      end
    end
  end
endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter with a synchronous ROM model and a write monitor.
module tb_sprite_blitter;
  import frame_pkg::*;
  localparam int W = 32, H = 32, IDW = 5, HOLD = 4;
  localparam int AW = IDW + 10;
  localparam int FULL = W * H * (1 + HOLD);

  logic          sram_clk = 1'b0, reset_n = 1'b0, current_frame = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data = '0, program_data;
  logic [9:0]    program_x, program_y;
  logic          program_write, busy, overrun;

  sprite_blitter_if #(.ID_W(IDW)) cmd_if();

  sprite_blitter #(.SPRITE_W(W), .SPRITE_H(H), .ID_W(IDW), .PIXEL_HOLD(HOLD)) dut (
    .sram_clk(sram_clk), .reset_n(reset_n), .cmd(cmd_if), .rom_addr(rom_addr),
    .rom_data(rom_data), .current_frame(current_frame), .program_x(program_x),
    .program_y(program_y), .program_data(program_data), .program_write(program_write),
    .busy(busy), .overrun(overrun));

  always #5 sram_clk = ~sram_clk;

  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ROM images: 0 = {0,addr}, 1 = key colour at even ROM columns, 2 = ROM column index
  int rom_mode = 0;
  function automatic logic [15:0] rom_fn(input logic [AW-1:0] a, input int mode);
    case (mode)
      1:       rom_fn = a[0] ? {1'b0, a} : 16'hF81F;
      2:       rom_fn = {11'd0, a[4:0]};
      default: rom_fn = {1'b0, a};
    endcase
  endfunction
  always @(posedge sram_clk) rom_data <= rom_fn(rom_addr, rom_mode);

  int cyc = 0;
  always @(posedge sram_clk) cyc <= cyc + 1;

  // command context shared with the monitor
  logic [9:0]     cx = '0, cy = '0;
  logic [IDW-1:0] cid = '0;
  int seq = 0, acc_cyc = 0, done_cyc = 0;

  function automatic logic [15:0] exp_pix(input int c, input int r, input int mode);
    case (mode)
      1:       exp_pix = c[0] ? {1'b0, cid, r[4:0], c[4:0]} : 16'hDEAD;
      2:       exp_pix = 16'(W - 1 - c);
      default: exp_pix = {1'b0, cid, r[4:0], c[4:0]};
    endcase
  endfunction

  int mseq = 0, wr_cyc = 0, wins = 0, bad = 0, ovr = 0, first_cyc = 0;
  logic [9:0]  first_x, first_y, last_x, last_y, px_d, py_d;
  logic [15:0] first_d, pd_d;
  logic        pw_d = 1'b0;
  always @(negedge sram_clk) begin
    int c, r;
    if (mseq != seq) begin
      mseq = seq; wr_cyc = 0; wins = 0; bad = 0; ovr = 0; pw_d = 1'b0;
    end
    if (overrun === 1'b1) ovr++;
    if (program_write === 1'b1) begin
      c = int'(program_x) - int'(cx);
      r = int'(program_y) - int'(cy);
      if (!pw_d) begin
        if (wins == 0) begin
          first_cyc = cyc; first_x = program_x; first_y = program_y; first_d = program_data;
        end
        wins++;
      end else if (program_x !== px_d || program_y !== py_d || program_data !== pd_d) bad++;
      last_x = program_x; last_y = program_y; wr_cyc++;
      if (c < 0 || c >= W || r < 0 || r >= H || program_x >= 10'd640 || program_y >= 10'd480) bad++;
      else if (program_data !== exp_pix(c, r, rom_mode)) bad++;
    end
    pw_d = program_write; px_d = program_x; py_d = program_y; pd_d = program_data;
  end

  task automatic send(input logic [9:0] x, input logic [9:0] y, input logic [IDW-1:0] id,
                      input logic flip, input int mode, input logic tog);
    @(negedge sram_clk);
    chk("ready_before_accept", 32'(cmd_if.cmd_ready), 1);
    cx = x; cy = y; cid = id; rom_mode = mode; seq++;
    cmd_if.cmd_x = x; cmd_if.cmd_y = y; cmd_if.cmd_id = id; cmd_if.cmd_flip = flip;
    cmd_if.cmd_valid = 1'b1;
    acc_cyc = cyc;
    if (tog) current_frame = ~current_frame;
    @(posedge sram_clk);
    #1 cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    do begin @(negedge sram_clk); n++; end
    while (cmd_if.cmd_ready !== 1'b1 && n < lim);
    done_cyc = cyc;
    chk("done_in_time", 32'(cmd_if.cmd_ready), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_x = '0; cmd_if.cmd_y = '0;
    cmd_if.cmd_id = '0; cmd_if.cmd_flip = 1'b0;

    repeat (3) @(posedge sram_clk);
    #1;
    chk("rst_ready", 32'(cmd_if.cmd_ready), 1);
    chk("rst_write", 32'(program_write), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_prog_x", 32'(program_x), 0);
    @(negedge sram_clk) reset_n = 1'b1;

    // opaque sprite id 2 at (100,50)
    send(10'd100, 10'd50, 5'd2, 1'b0, 0, 1'b0);
    chk("main_busy", 32'(busy), 1);
    chk("main_ready_low", 32'(cmd_if.cmd_ready), 0);
    wait_done(FULL + 100);
    chk("main_wins", wins, 1024);
    chk("main_wr_cycles", wr_cyc, 4096);
    chk("main_bad", bad, 0);
    chk("main_first_lat", first_cyc - acc_cyc, 2);
    chk("main_first_x", 32'(first_x), 100);
    chk("main_first_y", 32'(first_y), 50);
    chk("main_last_x", 32'(last_x), 131);
    chk("main_last_y", 32'(last_y), 81);
    chk("main_done_lat", done_cyc - acc_cyc, FULL + 1);

    // key colour at even columns
    send(10'd10, 10'd20, 5'd7, 1'b0, 1, 1'b0);
    wait_done(FULL + 100);
    chk("key_wins", wins, 512);
    chk("key_wr_cycles", wr_cyc, 2048);
    chk("key_bad", bad, 0);
    chk("key_done_lat", done_cyc - acc_cyc, FULL + 1);

    // partially off-screen: only a 10x10 corner is visible
    send(10'd630, 10'd470, 5'd1, 1'b0, 0, 1'b0);
    wait_done(FULL + 100);
    chk("clip_wins", wins, 100);
    chk("clip_bad", bad, 0);
    chk("clip_first_x", 32'(first_x), 630);
    chk("clip_first_y", 32'(first_y), 470);
    chk("clip_last_x", 32'(last_x), 639);
    chk("clip_last_y", 32'(last_y), 479);
    chk("clip_done_lat", done_cyc - acc_cyc, FULL + 1);

    // horizontal flip: screen column c shows ROM column W-1-c
    send(10'd200, 10'd100, 5'd3, 1'b1, 2, 1'b0);
    wait_done(FULL + 100);
    chk("flip_wins", wins, 1024);
    chk("flip_bad", bad, 0);
    chk("flip_first_x", 32'(first_x), 200);
    chk("flip_first_data", 32'(first_d), 31);
    chk("flip_last_x", 32'(last_x), 231);

    // frame switch while presenting pixel 300
    send(10'd100, 10'd50, 5'd2, 1'b0, 0, 1'b0);
    n = 0;
    do begin @(posedge sram_clk); #2; n++; end while (wins < 301 && n < 3000);
    chk("toggle_reached_px300", wins, 301);
    current_frame = ~current_frame;
    #1 chk("abort_write_drop", 32'(program_write), 0);
    @(posedge sram_clk); #2;
    chk("abort_ready", 32'(cmd_if.cmd_ready), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_overrun", 32'(overrun), 1);
    repeat (5) @(negedge sram_clk);
    chk("abort_ovr_count", ovr, 1);
    chk("abort_wr_cycles", wr_cyc, 300 * HOLD + 1);

    // frame switch on the accept cycle
    send(10'd10, 10'd10, 5'd4, 1'b0, 0, 1'b1);
    wait_done(50);
    chk("coinc_done_lat", done_cyc - acc_cyc, 2);
    repeat (4) @(negedge sram_clk);
    chk("coinc_wins", wins, 0);
    chk("coinc_ovr_count", ovr, 1);

    // normal command after the aborts
    send(10'd100, 10'd50, 5'd2, 1'b0, 0, 1'b0);
    wait_done(FULL + 100);
    chk("post_wins", wins, 1024);
    chk("post_bad", bad, 0);
    chk("post_ovr_count", ovr, 0);
    chk("post_done_lat", done_cyc - acc_cyc, FULL + 1);

    // reset in the middle of a sprite
    send(10'd0, 10'd0, 5'd5, 1'b0, 0, 1'b0);
    repeat (100) @(negedge sram_clk);
    reset_n = 1'b0;
    @(posedge sram_clk); #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_ready", 32'(cmd_if.cmd_ready), 1);
    chk("midrst_write", 32'(program_write), 0);
    chk("midrst_rom_addr", 32'(rom_addr), 0);
    chk("midrst_prog_y", 32'(program_y), 0);
    @(negedge sram_clk) reset_n = 1'b1;
    repeat (3) @(negedge sram_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
